biu_lsu: RTL and testbench

BIU_LSU -- requirements
Module: biu_lsu

---
 rtl/biu_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_biu_lsu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_lsu.sv
// biu_lsu -- load/store unit front end for a simple request/ack bus.
//
// Purpose:
//   Accepts one load or store per start pulse. It checks alignment, drives a
//   single bus request with lane-aligned byte enables and replicated store
//   data, and returns the aligned, sign/zero-extended load result with a
//   one-cycle done pulse. Misaligned accesses fault without touching the bus.
//
// Ports:
//   clk, rst_n             system clock (rising edge), async active-low reset
//   start                  request pulse, sampled in IDLE only
//   opc_biu[2:0]           001 w8, 010 w16, 011 w32, 101 r8, 110 r16, 111 r32
//   lb, lh                 sign-extend r8 / r16 results
//   addr[31:0]             byte address
//   wdata[31:0]            right-aligned store data
//   rdata[31:0]            load result, valid with done, held otherwise
//   done                   one-cycle completion pulse
//   busy                   transaction in flight
//   misalign, bus_err_o    completion status, valid with done
//   bus_req/we/addr/be/wdata   bus request side
//   bus_ack/err/rdata          bus response side
//
// Build option:
//   BIU_TIMEOUT_EN  -- when defined, a request that sees no ack for 255
//                      cycles is abandoned and completes with bus_err_o=1.
//                      When undefined, REQ waits for ack indefinitely.
//
// States:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE  00 | waiting for start
//   REQ   01 | bus_req asserted, waiting for bus_ack (or timeout)
//   RESP  10 | done pulse with load data / bus error status
//   FAULT 11 | done pulse with misalign=1, no bus access made

module biu_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  opc_biu,
  input  logic        lb,
  input  logic        lh,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        bus_err_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_RESP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t      r_state;
  logic [2:0]  r_opc;
  logic        r_lb;
  logic        r_lh;
  logic [1:0]  r_ofs;

`ifdef BIU_TIMEOUT_EN
  logic [7:0]  r_cnt;
`endif

  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_shifted;
  logic [31:0] w_rd_fmt;

  // Size decode on opc[1:0]: 01 byte, 10 half, anything else is a word.
  // The undefined code 100 therefore behaves as a 32-bit read.
  always_comb begin
    w_misalign  = 1'b0;
    w_be        = 4'b1111;
    w_wdata_rep = wdata;
    case (opc_biu[1:0])
      2'b01: begin
        w_be        = 4'b0001 << addr[1:0];
        w_wdata_rep = {4{wdata[7:0]}};
      end
      2'b10: begin
        w_misalign  = addr[0];
        w_be        = 4'b0011 << addr[1:0];
        w_wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        w_misalign  = |addr[1:0];
      end
    endcase
  end

  // Load formatting from the latched access; the shift is zero for words
  // because only aligned words ever reach the bus.
  always_comb begin
    w_shifted = bus_rdata >> {r_ofs, 3'b000};
    w_rd_fmt  = w_shifted;
    case (r_opc[1:0])
      2'b01:   w_rd_fmt = {{24{r_lb & w_shifted[7]}}, w_shifted[7:0]};
      2'b10:   w_rd_fmt = {{16{r_lh & w_shifted[15]}}, w_shifted[15:0]};
      default: w_rd_fmt = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_opc     <= 3'b000;
      r_lb      <= 1'b0;
      r_lh      <= 1'b0;
      r_ofs     <= 2'b00;
      rdata     <= 32'h0;
      done      <= 1'b0;
      busy      <= 1'b0;
      misalign  <= 1'b0;
      bus_err_o <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
`ifdef BIU_TIMEOUT_EN
      r_cnt     <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          done      <= 1'b0;
          misalign  <= 1'b0;
          bus_err_o <= 1'b0;
          if (start && (opc_biu != 3'b000)) begin
            r_opc <= opc_biu;
            r_lb  <= lb;
            r_lh  <= lh;
            r_ofs <= addr[1:0];
            busy  <= 1'b1;
            if (w_misalign) begin
              // Fault completes on the very next cycle, bus untouched.
              r_state  <= ST_FAULT;
              done     <= 1'b1;
              misalign <= 1'b1;
              rdata    <= 32'h0;
            end else begin
              r_state   <= ST_REQ;
              bus_req   <= 1'b1;
              bus_we    <= ~opc_biu[2];
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= w_be;
              bus_wdata <= w_wdata_rep;
`ifdef BIU_TIMEOUT_EN
              r_cnt     <= 8'd0;
`endif
            end
          end
        end

        ST_REQ: begin
          if (bus_ack) begin
            r_state   <= ST_RESP;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            done      <= 1'b1;
            bus_err_o <= bus_err;
            rdata     <= r_opc[2] ? w_rd_fmt : 32'h0;
          end
`ifdef BIU_TIMEOUT_EN
          // This is the 255th cycle without ack: the count reaches 255 and
          // the request is abandoned.
          else if (r_cnt == 8'd254) begin
            r_cnt     <= r_cnt + 8'd1;
            r_state   <= ST_RESP;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            done      <= 1'b1;
            bus_err_o <= 1'b1;
            rdata     <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end

        ST_RESP, ST_FAULT: begin
          r_state   <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          misalign  <= 1'b0;
          bus_err_o <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biu_lsu.sv
module tb_biu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opc_biu = 3'b000;
  logic        lb = 1'b0;
  logic        lh = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        misalign;
  logic        bus_err_o;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  biu_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opc_biu   (opc_biu),
    .lb        (lb),
    .lh        (lh),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .misalign  (misalign),
    .bus_err_o (bus_err_o),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mis;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   t_start = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected completion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata",      rdata,            mon_e.rd);
        chk("bus_err_o",  32'(bus_err_o),   32'(mon_e.err));
        chk("misalign",   32'(misalign),    32'(mon_e.mis));
        chk("done_cycle", 32'(cyc),         32'(mon_e.at));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic sx, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    start = 1'b1; opc_biu = op; lb = sx; lh = sx; addr = a; wdata = wd;
    t_start = cyc;
    @(posedge clk); #1;
    // Scramble the request inputs: they must be ignored once accepted.
    start = 1'b0; opc_biu = 3'($urandom); lb = 1'($urandom); lh = 1'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  task automatic check_bus(input logic [3:0] be, input logic [31:0] a, input logic we, input logic [31:0] wd);
    chk("bus_req",  32'(bus_req), 32'd1);
    chk("busy",     32'(busy),    32'd1);
    chk("bus_be",   32'(bus_be),  32'(be));
    chk("bus_addr", bus_addr,     a);
    chk("bus_we",   32'(bus_we),  32'(we));
    if (we) chk("bus_wdata", bus_wdata, wd);
  endtask

  // Responder: ack after wait_n extra REQ cycles; poke drives start while busy
  // and during the done cycle, which must not produce another transaction.
  task automatic serve(input int wait_n, input logic [31:0] rd, input logic ev,
                       input logic [31:0] exp_rd, input bit poke);
    for (int i = 0; i < wait_n; i++) begin
      if (poke) begin start = 1'b1; opc_biu = 3'b111; addr = 32'h0; end
      @(posedge clk); #1;
    end
    chk("req_hold", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_err = ev; bus_rdata = rd;
    sb.push_back('{exp_rd, ev, 1'b0, cyc + 1});
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    if (poke) begin start = 1'b1; opc_biu = 3'b101; addr = 32'h0; end
    chk("req_drop", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic misaligned(input logic [2:0] op, input logic [31:0] a);
    issue(op, 1'b0, a, 32'h0);
    sb.push_back('{32'h0, 1'b0, 1'b1, t_start + 1});
    chk("fault_no_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    chk("fault_no_req2", 32'(bus_req), 32'd0);
    chk("fault_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_dones;
    exp_dones = 10;
    #12;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_bus_be",  32'(bus_be),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // r8 signed, top lane, zero-wait
    issue(3'b101, 1'b1, 32'h0000_1003, 32'h0);
    check_bus(4'b1000, 32'h0000_1000, 1'b0, 32'h0);
    serve(0, 32'h80AA_BBCC, 1'b0, 32'hFFFF_FF80, 1'b0);
    // ack outside REQ is ignored and rdata holds
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 bus_ack = 1'b0;
    chk("rdata_hold", rdata, 32'hFFFF_FF80);

    // w16 upper half, with start pokes while busy and during done
    issue(3'b010, 1'b0, 32'h0000_2002, 32'h0000_1234);
    check_bus(4'b1100, 32'h0000_2000, 1'b1, 32'h1234_1234);
    serve(2, $urandom, 1'b0, 32'h0, 1'b1);

    misaligned(3'b111, 32'h0000_3001);

    // r16 unsigned with bus error
    issue(3'b110, 1'b0, 32'h0000_4000, 32'h0);
    check_bus(4'b0011, 32'h0000_4000, 1'b0, 32'h0);
    serve(1, 32'h0000_F00D, 1'b1, 32'h0000_F00D, 1'b0);

    // r16 signed upper half
    issue(3'b110, 1'b1, 32'h0000_4002, 32'h0);
    check_bus(4'b1100, 32'h0000_4000, 1'b0, 32'h0);
    serve(0, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b0);

    // r8 unsigned lane 0
    issue(3'b101, 1'b0, 32'h0000_0010, 32'h0);
    check_bus(4'b0001, 32'h0000_0010, 1'b0, 32'h0);
    serve(3, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 1'b0);

    // w8 lane 3
    issue(3'b001, 1'b0, 32'h0000_0007, 32'h0000_00AB);
    check_bus(4'b1000, 32'h0000_0004, 1'b1, 32'hABAB_ABAB);
    serve(0, $urandom, 1'b0, 32'h0, 1'b0);

    misaligned(3'b010, 32'h0000_0005);

    // r32
    issue(3'b111, 1'b0, 32'h0000_0008, 32'h0);
    check_bus(4'b1111, 32'h0000_0008, 1'b0, 32'h0);
    serve(1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // async reset mid-REQ, then a start accepted on the first edge
    issue(3'b011, 1'b0, 32'h0000_6000, 32'hCAFE_0000);
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus_req",   32'(bus_req), 32'd0);
    chk("arst_busy",      32'(busy),    32'd0);
    chk("arst_bus_be",    32'(bus_be),  32'd0);
    chk("arst_bus_addr",  bus_addr,     32'h0);
    chk("arst_bus_wdata", bus_wdata,    32'h0);
    chk("arst_rdata",     rdata,        32'h0);
    start = 1'b1; opc_biu = 3'b011; addr = 32'h0; wdata = 32'h1122_3344;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_bus(4'b1111, 32'h0, 1'b1, 32'h1122_3344);
    serve(0, $urandom, 1'b0, 32'h0, 1'b0);

    // unanswered request
    issue(3'b111, 1'b0, 32'h0000_5000, 32'h0);
`ifdef BIU_TIMEOUT_EN
    begin
      int n_req;
      int k;
      exp_dones = 11;
      n_req = 0;
      k = 0;
      sb.push_back('{32'h0, 1'b1, 1'b0, t_start + 256});
      while (!done && k < 400) begin
        @(negedge clk);
        if (bus_req) n_req++;
        k++;
      end
      chk("timeout_req_cycles", 32'(n_req), 32'd255);
      chk("timeout_done",       32'(done),  32'd1);
      @(posedge clk); #1;
    end
`else
    repeat (1000) @(negedge clk);
    chk("no_timeout_req",  32'(bus_req), 32'd1);
    chk("no_timeout_busy", 32'(busy),    32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done),    32'(exp_dones));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
